// File: rtl/riesgos_pkg.sv
// Shared types, state encodings and forwarding selects for the pipeline hazard controller.
package riesgos_pkg;

  // Widest register specifier the shadow slots can hold; narrower specifiers are zero-extended.
  localparam int unsigned ANCHO_DEST = 8;

  typedef enum logic [1:0] {
    EST_NORMAL = 2'b00,
    EST_FLUSH  = 2'b01
  } estado_t;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic                  valido;
    logic [ANCHO_DEST-1:0] destino;
    logic                  escribe;
  } escritor_t;

  typedef struct packed {
    escritor_t esc;
    logic      lee_mem;
  } slot_t;

  // Register $0 is hard-wired, so a slot targeting it never produces a value.
  function automatic logic es_escritor(escritor_t s);
    return s.valido && s.escribe && (s.destino != '0);
  endfunction

endpackage

// File: rtl/unidad_forwarding.sv
// Picks the forwarding source for one ALU operand from the two in-flight producer slots.
module unidad_forwarding
  import riesgos_pkg::*;
(
  input  logic [ANCHO_DEST-1:0] fuente,
  input  escritor_t             slot_ex,
  input  escritor_t             slot_mem,
  output logic [1:0]            sel_c
);

  // The younger producer (about to enter MEM) holds the newest value and wins.
  always_comb begin
    sel_c = FWD_REG;
    if (es_escritor(slot_ex) && (slot_ex.destino == fuente)) begin
      sel_c = FWD_MEM;
    end else if (es_escritor(slot_mem) && (slot_mem.destino == fuente)) begin
      sel_c = FWD_WB;
    end
  end

endmodule

// File: rtl/control_riesgos.sv
// Hazard controller for the 5-stage pipeline: load-use stalls, registered EX forwarding
// selects and the branch-taken flush sequence.
module control_riesgos
  import riesgos_pkg::*;
#(
  parameter int unsigned FLUSH_CICLOS = 1,
  parameter int unsigned ANCHO_REG    = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_valido,
  input  logic [ANCHO_REG-1:0] id_rs,
  input  logic [ANCHO_REG-1:0] id_rt,
  input  logic                 id_usa_rs,
  input  logic                 id_usa_rt,
  input  logic [ANCHO_REG-1:0] id_reg_destino,
  input  logic                 id_escribe_reg,
  input  logic                 id_lee_mem,
  input  logic                 branch_habilitado_EX,
  output logic                 pc_write,
  output logic                 if_id_write,
  output logic                 id_ex_burbuja,
  output logic                 if_id_flush,
  output logic                 id_ex_flush,
  output logic [1:0]           fwd_a_EX,
  output logic [1:0]           fwd_b_EX,
  output logic [1:0]           estado
);

  localparam int unsigned ANCHO_CNT = 2;

  estado_t               est_q, est_d;
  logic [ANCHO_CNT-1:0]  cnt_q, cnt_d;
  slot_t                 ex_q, ex_d;
  escritor_t             mem_q;
  logic [1:0]            fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;
  logic [1:0]            sel_a_c, sel_b_c;
  logic [ANCHO_DEST-1:0] rs_c, rt_c, dest_c;
  logic                  ramal_c, flush_c, riesgo_c, stall_c, carga_c;

  assign rs_c   = ANCHO_DEST'(id_rs);
  assign rt_c   = ANCHO_DEST'(id_rt);
  assign dest_c = ANCHO_DEST'(id_reg_destino);

  // A taken branch only counts in NORMAL; reset masks it so flush outputs clear immediately.
  assign ramal_c = rst_n && (est_q == EST_NORMAL) && branch_habilitado_EX;
  assign flush_c = ramal_c || (est_q == EST_FLUSH);

  assign riesgo_c = id_valido && ex_q.esc.valido && ex_q.lee_mem && (ex_q.esc.destino != '0) &&
                    ((id_usa_rs && (rs_c == ex_q.esc.destino)) ||
                     (id_usa_rt && (rt_c == ex_q.esc.destino)));
  assign stall_c  = riesgo_c && !flush_c;
  assign carga_c  = id_valido && !stall_c && !flush_c;

  unidad_forwarding u_fwd_a (
    .fuente   (rs_c),
    .slot_ex  (ex_q.esc),
    .slot_mem (mem_q),
    .sel_c    (sel_a_c)
  );

  unidad_forwarding u_fwd_b (
    .fuente   (rt_c),
    .slot_ex  (ex_q.esc),
    .slot_mem (mem_q),
    .sel_c    (sel_b_c)
  );

  // Next contents of the EX shadow slot and the selects that travel with it.
  always_comb begin
    ex_d    = '0;
    fwd_a_d = FWD_REG;
    fwd_b_d = FWD_REG;
    if (carga_c) begin
      ex_d.esc.valido  = 1'b1;
      ex_d.esc.destino = dest_c;
      ex_d.esc.escribe = id_escribe_reg;
      ex_d.lee_mem     = id_lee_mem;
      if (id_usa_rs) fwd_a_d = sel_a_c;
      if (id_usa_rt) fwd_b_d = sel_b_c;
    end
  end

  // Flush sequencing: FLUSH lasts exactly FLUSH_CICLOS cycles.
  always_comb begin
    est_d = est_q;
    cnt_d = cnt_q;
    case (est_q)
      EST_NORMAL: begin
        if (ramal_c) begin
          est_d = EST_FLUSH;
          cnt_d = ANCHO_CNT'(FLUSH_CICLOS);
        end
      end
      EST_FLUSH: begin
        if (cnt_q <= ANCHO_CNT'(1)) begin
          est_d = EST_NORMAL;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q - ANCHO_CNT'(1);
        end
      end
      default: begin
        est_d = EST_NORMAL;
        cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      est_q   <= EST_NORMAL;
      cnt_q   <= '0;
      ex_q    <= '0;
      mem_q   <= '0;
      fwd_a_q <= FWD_REG;
      fwd_b_q <= FWD_REG;
    end else begin
      est_q   <= est_d;
      cnt_q   <= cnt_d;
      ex_q    <= ex_d;
      mem_q   <= ex_q.esc;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign pc_write      = !stall_c;
  assign if_id_write   = !stall_c;
  assign id_ex_burbuja = stall_c;
  assign if_id_flush   = flush_c;
  assign id_ex_flush   = ramal_c;
  assign fwd_a_EX      = fwd_a_q;
  assign fwd_b_EX      = fwd_b_q;
  assign estado        = est_q;

endmodule

// File: tb/tb_control_riesgos.sv
// Scoreboard bench: an instruction-level pipeline model predicts each cycle's outputs for two
// controllers (FLUSH_CICLOS 1 and 2); a monitor compares them on the falling edge.
module tb_control_riesgos;

  localparam int unsigned AR   = 5;
  localparam int unsigned ND   = 2;
  localparam int          NCYC = 700;

  typedef struct {
    logic          v;
    logic [AR-1:0] rs, rt, rd;
    logic          urs, urt, esc, lee, br;
  } instr_t;

  typedef struct {
    logic          v;
    logic [AR-1:0] rd;
    logic          esc, lee;
  } prod_t;

  typedef struct {
    int         d;
    logic [1:0] pc_w, ifid_w, burb, fl_if, fl_ex, fa, fb, est;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic          id_valido [ND];
  logic [AR-1:0] id_rs [ND];
  logic [AR-1:0] id_rt [ND];
  logic          id_usa_rs [ND];
  logic          id_usa_rt [ND];
  logic [AR-1:0] id_reg_destino [ND];
  logic          id_escribe_reg [ND];
  logic          id_lee_mem [ND];
  logic          branch [ND];
  logic          pc_write [ND];
  logic          if_id_write [ND];
  logic          id_ex_burbuja [ND];
  logic          if_id_flush [ND];
  logic          id_ex_flush [ND];
  logic [1:0]    fwd_a [ND];
  logic [1:0]    fwd_b [ND];
  logic [1:0]    estado [ND];

  always #5 clk = ~clk;

  control_riesgos #(.FLUSH_CICLOS(1), .ANCHO_REG(AR)) dut0 (
    .clk(clk), .rst_n(rst_n), .id_valido(id_valido[0]), .id_rs(id_rs[0]), .id_rt(id_rt[0]),
    .id_usa_rs(id_usa_rs[0]), .id_usa_rt(id_usa_rt[0]), .id_reg_destino(id_reg_destino[0]),
    .id_escribe_reg(id_escribe_reg[0]), .id_lee_mem(id_lee_mem[0]),
    .branch_habilitado_EX(branch[0]), .pc_write(pc_write[0]), .if_id_write(if_id_write[0]),
    .id_ex_burbuja(id_ex_burbuja[0]), .if_id_flush(if_id_flush[0]), .id_ex_flush(id_ex_flush[0]),
    .fwd_a_EX(fwd_a[0]), .fwd_b_EX(fwd_b[0]), .estado(estado[0]));

  control_riesgos #(.FLUSH_CICLOS(2), .ANCHO_REG(AR)) dut1 (
    .clk(clk), .rst_n(rst_n), .id_valido(id_valido[1]), .id_rs(id_rs[1]), .id_rt(id_rt[1]),
    .id_usa_rs(id_usa_rs[1]), .id_usa_rt(id_usa_rt[1]), .id_reg_destino(id_reg_destino[1]),
    .id_escribe_reg(id_escribe_reg[1]), .id_lee_mem(id_lee_mem[1]),
    .branch_habilitado_EX(branch[1]), .pc_write(pc_write[1]), .if_id_write(if_id_write[1]),
    .id_ex_burbuja(id_ex_burbuja[1]), .if_id_flush(if_id_flush[1]), .id_ex_flush(id_ex_flush[1]),
    .fwd_a_EX(fwd_a[1]), .fwd_b_EX(fwd_b[1]), .estado(estado[1]));

  // Model state: hist[d][0] is the instruction now in EX, hist[d][1] the one in MEM.
  instr_t     cur [ND];
  instr_t     prog [ND][$];
  prod_t      hist [ND][2];
  prod_t      nnew [ND];
  int         fl_left [ND];
  int         nfl [ND];
  logic [1:0] fa_q [ND], fb_q [ND], nfa [ND], nfb [ND];
  logic       n_bub [ND], n_fetch [ND], ld_now [ND];
  exp_t       e_cur [ND];
  exp_t       sb [$];
  int         vecs = 0;
  int         errs = 0;
  int         rst_hold;
  int         nr_fl = 0;
  int         nr_st = 0;

  function automatic int flush_len(int d);
    return (d == 0) ? 1 : 2;
  endfunction

  function automatic instr_t burbuja();
    instr_t i;
    i = '{default: '0};
    return i;
  endfunction

  function automatic instr_t ins(int rs, int rt, bit urs, bit urt, int rd, bit esc, bit lee, bit br);
    instr_t i;
    i.v = 1'b1; i.rs = AR'(rs); i.rt = AR'(rt); i.urs = urs; i.urt = urt;
    i.rd = AR'(rd); i.esc = esc; i.lee = lee; i.br = br;
    return i;
  endfunction

  function automatic instr_t aleatoria();
    instr_t i;
    i.v   = ($urandom_range(7) != 0);
    i.rs  = AR'($urandom_range(3));
    i.rt  = AR'($urandom_range(3));
    i.rd  = AR'($urandom_range(3));
    i.urs = ($urandom_range(3) != 0);
    i.urt = ($urandom_range(1) == 1);
    i.esc = ($urandom_range(3) != 0);
    i.lee = ($urandom_range(3) == 0);
    i.br  = ($urandom_range(11) == 0);
    return i;
  endfunction

  // Newest older producer of src among the two instructions ahead of it.
  function automatic logic [1:0] elige_fwd(int d, logic [AR-1:0] src);
    for (int k = 0; k < 2; k++) begin
      if (hist[d][k].v && hist[d][k].esc && hist[d][k].rd != '0 && hist[d][k].rd == src)
        return (k == 0) ? 2'b10 : 2'b01;
    end
    return 2'b00;
  endfunction

  task automatic model_reset(int d);
    hist[d][0] = '{default: '0};
    hist[d][1] = '{default: '0};
    fl_left[d] = 0;
    fa_q[d] = 2'b00;
    fb_q[d] = 2'b00;
    cur[d] = burbuja();
  endtask

  task automatic paso(int d);
    logic  en_fl, br_now, ld, carga;
    prod_t ex;
    exp_t  e;
    id_valido[d] = cur[d].v;           id_rs[d] = cur[d].rs;   id_rt[d] = cur[d].rt;
    id_usa_rs[d] = cur[d].urs;         id_usa_rt[d] = cur[d].urt;
    id_reg_destino[d] = cur[d].rd;     id_escribe_reg[d] = cur[d].esc;
    id_lee_mem[d] = cur[d].lee;        branch[d] = cur[d].br;
    ex     = hist[d][0];
    en_fl  = fl_left[d] > 0;
    br_now = (rst_n == 1'b1) && !en_fl && cur[d].br;
    ld = cur[d].v && ex.v && ex.lee && ex.rd != '0 &&
         ((cur[d].urs && cur[d].rs == ex.rd) || (cur[d].urt && cur[d].rt == ex.rd)) && !br_now;
    ld_now[d] = ld;
    e.d = d;
    e.pc_w = {1'b0, !ld};  e.ifid_w = {1'b0, !ld};  e.burb = {1'b0, ld};
    e.fl_if = {1'b0, br_now || en_fl};  e.fl_ex = {1'b0, br_now};
    e.est = en_fl ? 2'b01 : 2'b00;  e.fa = fa_q[d];  e.fb = fb_q[d];
    e_cur[d] = e;
    carga = cur[d].v && !ld && !br_now && !en_fl;
    nnew[d] = '{default: '0};
    nfa[d] = 2'b00;
    nfb[d] = 2'b00;
    if (carga) begin
      nnew[d].v = 1'b1; nnew[d].rd = cur[d].rd; nnew[d].esc = cur[d].esc; nnew[d].lee = cur[d].lee;
      if (cur[d].urs) nfa[d] = elige_fwd(d, cur[d].rs);
      if (cur[d].urt) nfb[d] = elige_fwd(d, cur[d].rt);
    end
    nfl[d]     = br_now ? flush_len(d) : (en_fl ? fl_left[d] - 1 : 0);
    n_bub[d]   = br_now || en_fl;
    n_fetch[d] = !ld;
  endtask

  task automatic commit(int d);
    hist[d][1] = hist[d][0];
    hist[d][0] = nnew[d];
    fl_left[d] = nfl[d];
    fa_q[d] = nfa[d];
    fb_q[d] = nfb[d];
    if (n_bub[d]) begin
      cur[d] = burbuja();
    end else if (n_fetch[d]) begin
      if (prog[d].size() == 0) prog[d].push_back(aleatoria());
      cur[d] = prog[d].pop_front();
    end
  endtask

  task automatic chk(string n, int d, logic [1:0] a, logic [1:0] x);
    vecs++;
    if (a !== x) begin
      errs++;
      $display("FAIL %s dut%0d at %0t: got %0b expected %0b", n, d, $time, a, x);
    end
  endtask

  // Monitor: drains every expectation queued for this cycle.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() != 0) begin
        e = sb.pop_front();
        chk("pc_write",      e.d, {1'b0, pc_write[e.d]},      e.pc_w);
        chk("if_id_write",   e.d, {1'b0, if_id_write[e.d]},   e.ifid_w);
        chk("id_ex_burbuja", e.d, {1'b0, id_ex_burbuja[e.d]}, e.burb);
        chk("if_id_flush",   e.d, {1'b0, if_id_flush[e.d]},   e.fl_if);
        chk("id_ex_flush",   e.d, {1'b0, id_ex_flush[e.d]},   e.fl_ex);
        chk("fwd_a_EX",      e.d, fwd_a[e.d],                 e.fa);
        chk("fwd_b_EX",      e.d, fwd_b[e.d],                 e.fb);
        chk("estado",        e.d, estado[e.d],                e.est);
      end
    end
  end

  initial begin : driver
    logic do_rst;
    rst_n = 1'b0;
    rst_hold = 1;
    for (int d = 0; d < ND; d++) begin
      model_reset(d);
      // add/sub back-to-back, distance-2 forward, MEM priority, load-use, $0, branch over load-use
      prog[d] = '{ins(1,2,1,1,3,1,0,0), ins(3,5,1,1,4,1,0,0), ins(0,0,0,0,0,0,0,0),
                  ins(1,2,1,1,3,1,0,0), ins(0,0,0,0,0,0,0,0), ins(7,3,1,1,6,1,0,0),
                  ins(1,2,1,1,3,1,0,0), ins(1,0,1,0,3,1,0,0), ins(3,2,1,1,7,1,0,0),
                  ins(1,0,1,0,2,1,1,0), ins(2,2,1,1,4,1,0,0), ins(0,0,0,0,0,0,0,0),
                  ins(1,0,1,0,0,1,1,0), ins(0,0,1,1,5,1,0,0), ins(1,2,1,1,0,1,0,0),
                  ins(0,0,1,1,6,1,0,0), ins(1,0,1,0,2,1,1,0), ins(2,2,1,1,4,1,0,1),
                  ins(0,0,0,0,0,0,0,0), ins(0,0,0,0,0,0,0,0), ins(0,0,0,0,0,0,0,0)};
    end
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      if (rst_n) for (int d = 0; d < ND; d++) commit(d);
      #1;
      if (!rst_n) begin
        if (rst_hold == 0) rst_n = 1'b1;
        else rst_hold--;
      end
      for (int d = 0; d < ND; d++) paso(d);
      do_rst = 1'b0;
      if (rst_n && c > 40) begin
        if (fl_left[1] > 0 && nr_fl < 2 && $urandom_range(2) == 0) begin
          do_rst = 1'b1; nr_fl++;
        end else if (ld_now[0] && nr_st < 2 && $urandom_range(2) == 0) begin
          do_rst = 1'b1; nr_st++;
        end
      end
      if (do_rst) begin
        #1;
        rst_n = 1'b0;
        rst_hold = 0;
        for (int d = 0; d < ND; d++) begin
          model_reset(d);
          prog[d].push_front(ins(3,5,1,1,4,1,0,0));
          prog[d].push_front(ins(1,2,1,1,3,1,0,0));
          paso(d);
        end
      end
      for (int d = 0; d < ND; d++) sb.push_back(e_cur[d]);
    end
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      vecs++;
      errs++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
